// File: rtl/sim_monitor.sv
// ---------------------------------------------------------------------------
// sim_monitor
//
// End-of-test monitor for core simulation benches. It watches each core's
// fetch PC and its MMIO "tohost" store port. It reports pass, fail or
// timeout with a cycle count, so the bench can stop on an event instead of
// after a fixed delay.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset, aborts the test
//   pc_addr      packed fetch PCs, core i at [i*ADDR_W +: ADDR_W]
//   mmio_we      per-core store strobe, valid for one cycle
//   mmio_addr    packed store addresses
//   mmio_wdata   packed store data, 32 bits per core
//   core_halted  sticky per-core finished flag
//   done         sticky, test finished
//   pass         with done: every core finished, no fail, no timeout
//   fail         with done: some core reported a failure
//   timeout      with done: cycle budget exhausted
//   fail_core    index of the failing core (lowest index on a tie)
//   fail_code    failing core's wdata >> 1
//   cycle_count  cycles spent in RUN, saturating
// ---------------------------------------------------------------------------
module sim_monitor #(
    parameter int                NUM_CORES      = 1,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
    parameter int                TIMEOUT_CYCLES = 5000,
    parameter int                STALL_LIMIT    = 16,
    parameter int                CNT_W          = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES*ADDR_W-1:0] pc_addr,
    input  logic [NUM_CORES-1:0]        mmio_we,
    input  logic [NUM_CORES*ADDR_W-1:0] mmio_addr,
    input  logic [NUM_CORES*32-1:0]     mmio_wdata,
    output logic [NUM_CORES-1:0]        core_halted,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [2:0]                  fail_core,
    output logic [31:0]                 fail_code,
    output logic [CNT_W-1:0]            cycle_count
);

    localparam int                 STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0]   LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q    [NUM_CORES];
    logic [ADDR_W-1:0]    pc_d    [NUM_CORES];
    logic [STALL_W-1:0]   stall_q [NUM_CORES];
    logic [STALL_W-1:0]   stall_d [NUM_CORES];
    logic [NUM_CORES-1:0] halted_q, halted_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 timeout_q, timeout_d;
    logic [2:0]           fail_core_q, fail_core_d;
    logic [31:0]          fail_code_q, fail_code_d;
    logic [CNT_W-1:0]     cycle_q, cycle_d;

    // Per-core views of the packed input buses.
    logic [ADDR_W-1:0]    pc_in    [NUM_CORES];
    logic [31:0]          wdata_in [NUM_CORES];
    logic [NUM_CORES-1:0] tohost_hit;

    // Lowest-index failure seen this cycle.
    logic                 fail_found;
    logic [2:0]           fail_idx;
    logic [31:0]          fail_val;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign pc_in[g]      = pc_addr[g*ADDR_W +: ADDR_W];
        assign wdata_in[g]   = mmio_wdata[g*32 +: 32];
        // A core that has already finished can no longer report anything.
        assign tohost_hit[g] = mmio_we[g]
                            && (mmio_addr[g*ADDR_W +: ADDR_W] == TOHOST_ADDR)
                            && !halted_q[g];
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        pc_d        = pc_q;
        stall_d     = stall_q;
        halted_d    = halted_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_core_d = fail_core_q;
        fail_code_d = fail_code_q;
        cycle_d     = cycle_q;
        fail_found  = 1'b0;
        fail_idx    = '0;
        fail_val    = '0;

        case (state_q)
            ST_START: begin
                // Seed the PC history so the first RUN compare is meaningful.
                for (int i = 0; i < NUM_CORES; i++) begin
                    pc_d[i] = pc_in[i];
                end
                state_d = ST_RUN;
            end

            ST_RUN: begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (pc_in[i] == pc_q[i]) begin
                        stall_d[i] = (stall_q[i] == STALL_MAX)
                                   ? stall_q[i] : stall_q[i] + STALL_W'(1);
                    end else begin
                        stall_d[i] = '0;
                    end
                    pc_d[i] = pc_in[i];

                    // Finished on a "j ." self-loop or a tohost value of 1.
                    if ((tohost_hit[i] && (wdata_in[i] == 32'd1))
                        || (stall_d[i] == STALL_MAX)) begin
                        halted_d[i] = 1'b1;
                    end

                    // Any value other than 0 or 1 is a failure report; the
                    // loop runs upward, so the first hit is the lowest index.
                    if (tohost_hit[i] && (wdata_in[i] > 32'd1) && !fail_found) begin
                        fail_found = 1'b1;
                        fail_idx   = 3'(i);
                        fail_val   = wdata_in[i] >> 1;
                    end
                end

                cycle_d = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);

                // Priority: fail, then all finished, then timeout.
                if (fail_found) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    fail_d      = 1'b1;
                    fail_core_d = fail_idx;
                    fail_code_d = fail_val;
                end else if (&halted_d) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (cycle_q == LAST_CYCLE) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end

            ST_DONE: begin
                // Results are final; inputs are ignored until reset.
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            // NOTE: the per-core PC and stall arrays are reset too, because a
            // mid-run reset must restart the halt detection from scratch.
            for (int i = 0; i < NUM_CORES; i++) begin
                pc_q[i]    <= '0;
                stall_q[i] <= '0;
            end
            halted_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_core_q <= '0;
            fail_code_q <= '0;
            cycle_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register updates
            // from the values computed before this edge.
            state_q     <= state_d;
            pc_q        <= pc_d;
            stall_q     <= stall_d;
            halted_q    <= halted_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_core_q <= fail_core_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= cycle_d;
        end
    end

    assign core_halted = halted_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign fail_core   = fail_core_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_sim_monitor.sv
// ---------------------------------------------------------------------------
// tb_sim_monitor
//
// Bench for sim_monitor with four cores and a short timeout. A reference
// model tracks, per core, the previous PC, how long it has been repeated,
// and whether the core has finished. Every cycle the DUT outputs are compared
// with that model. A table of directed scenarios adds fixed expected results.
// Hand-written sequences cover sticky halting and a reset during RUN.
// Random scenarios finish the run.
// ---------------------------------------------------------------------------
module tb_sim_monitor;

    localparam int          NC     = 4;
    localparam int          AW     = 32;
    localparam int          TO     = 120;
    localparam int          SL     = 16;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC*AW-1:0]  pc_addr;
    logic [NC-1:0]     mmio_we;
    logic [NC*AW-1:0]  mmio_addr;
    logic [NC*32-1:0]  mmio_wdata;
    logic [NC-1:0]     core_halted;
    logic              done, pass, fail, timeout;
    logic [2:0]        fail_core;
    logic [31:0]       fail_code;
    logic [31:0]       cycle_count;

    sim_monitor #(
        .NUM_CORES     (NC),
        .ADDR_W        (AW),
        .TOHOST_ADDR   (TOHOST),
        .TIMEOUT_CYCLES(TO),
        .STALL_LIMIT   (SL),
        .CNT_W         (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_addr    (pc_addr),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .core_halted(core_halted),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .fail_core  (fail_core),
        .fail_code  (fail_code),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-core stimulus, packed onto the DUT buses by apply().
    logic [31:0] s_pc    [NC];
    logic        s_we    [NC];
    logic [31:0] s_addr  [NC];
    logic [31:0] s_wdata [NC];

    // Reference model state.
    int          m_phase;          // 0: waiting for first cycle, 1: running, 2: finished
    logic [31:0] m_prev_pc [NC];
    int          m_same    [NC];   // consecutive cycles with a repeated PC
    bit          m_fin     [NC];
    longint      m_cycles;
    bit          m_done, m_pass, m_fail, m_to;
    int          m_fcore;
    logic [31:0] m_fcode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NC; i++) begin
            pc_addr[i*AW +: AW]    = s_pc[i];
            mmio_we[i]             = s_we[i];
            mmio_addr[i*AW +: AW]  = s_addr[i];
            mmio_wdata[i*32 +: 32] = s_wdata[i];
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_cycles = 0;
        m_done   = 0;
        m_pass   = 0;
        m_fail   = 0;
        m_to     = 0;
        m_fcore  = 0;
        m_fcode  = '0;
        for (int i = 0; i < NC; i++) begin
            m_prev_pc[i] = '0;
            m_same[i]    = 0;
            m_fin[i]     = 0;
        end
    endtask

    // One rising edge of the reference model, using the current stimulus.
    task automatic model_step();
        int          first_fail;
        logic [31:0] code;
        bit          all_fin;
        bit          last_cycle;
        first_fail = -1;
        code       = '0;
        if (m_phase == 0) begin
            for (int i = 0; i < NC; i++) m_prev_pc[i] = s_pc[i];
            m_phase = 1;
        end else if (m_phase == 1) begin
            last_cycle = (m_cycles == TO - 1);
            for (int i = 0; i < NC; i++) begin
                if (s_pc[i] == m_prev_pc[i]) begin
                    if (m_same[i] < SL) m_same[i]++;
                end else begin
                    m_same[i] = 0;
                end
                m_prev_pc[i] = s_pc[i];
                if (!m_fin[i] && s_we[i] && s_addr[i] == TOHOST) begin
                    if (s_wdata[i] == 1) begin
                        m_fin[i] = 1;
                    end else if (s_wdata[i] != 0 && first_fail < 0) begin
                        first_fail = i;
                        code       = s_wdata[i] >> 1;
                    end
                end
                if (m_same[i] == SL) m_fin[i] = 1;
            end
            if (m_cycles < 64'h0000_0000_FFFF_FFFF) m_cycles++;
            all_fin = 1;
            for (int i = 0; i < NC; i++) if (!m_fin[i]) all_fin = 0;
            if (first_fail >= 0) begin
                m_done = 1; m_fail = 1; m_fcore = first_fail; m_fcode = code; m_phase = 2;
            end else if (all_fin) begin
                m_done = 1; m_pass = 1; m_phase = 2;
            end else if (last_cycle) begin
                m_done = 1; m_to = 1; m_phase = 2;
            end
        end
    endtask

    task automatic compare_model();
        logic [NC-1:0] hm;
        for (int i = 0; i < NC; i++) hm[i] = m_fin[i];
        check("model.core_halted", core_halted, hm);
        check("model.done",        done,        m_done);
        check("model.pass",        pass,        m_pass);
        check("model.fail",        fail,        m_fail);
        check("model.timeout",     timeout,     m_to);
        check("model.fail_core",   fail_core,   m_fcore[2:0]);
        check("model.fail_code",   fail_code,   m_fcode);
        check("model.cycle_count", cycle_count, m_cycles[31:0]);
    endtask

    // One clock cycle: inputs were set before, the model follows the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NC; i++) begin
            s_pc[i] = '0; s_we[i] = 1'b0; s_addr[i] = '0; s_wdata[i] = '0;
        end
        apply();
        model_reset();
        #1;
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Masked cores sit on a fixed PC; the others advance every cycle.
    task automatic drive_idle(input int t, input logic [NC-1:0] mask);
        for (int i = 0; i < NC; i++) begin
            s_pc[i]    = mask[i] ? 32'h40 : 32'(i * 256 + 4 * t);
            s_we[i]    = 1'b0;
            s_addr[i]  = '0;
            s_wdata[i] = '0;
        end
        apply();
    endtask

    // After done: random traffic, including tohost stores, must change nothing.
    task automatic post_done_noise();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                s_pc[i]    = $urandom;
                s_we[i]    = 1'b1;
                s_addr[i]  = TOHOST;
                s_wdata[i] = $urandom_range(0, 9);
            end
            apply();
            cycle();
        end
    endtask

    typedef struct {
        logic [NC-1:0] mask;     // cores parked on a fixed PC from the start
        int            st_cyc;   // RUN cycle of the store(s), -1 for none
        int            st_core;
        logic [31:0]   st_addr;
        logic [31:0]   st_wd;
        int            st2_core; // second store in the same cycle, -1 for none
        logic [31:0]   st2_wd;
        bit            e_pass;
        bit            e_fail;
        bit            e_to;
        logic [2:0]    e_core;
        logic [31:0]   e_code;
        logic [31:0]   e_cc;
        logic [NC-1:0] e_halt;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input int n, input vec_t v);
        reset_dut();
        drive_idle(0, v.mask);
        cycle();
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            drive_idle(k + 1, v.mask);
            if (k == v.st_cyc) begin
                s_we[v.st_core]    = 1'b1;
                s_addr[v.st_core]  = v.st_addr;
                s_wdata[v.st_core] = v.st_wd;
                if (v.st2_core >= 0) begin
                    s_we[v.st2_core]    = 1'b1;
                    s_addr[v.st2_core]  = TOHOST;
                    s_wdata[v.st2_core] = v.st2_wd;
                end
                apply();
            end
            cycle();
        end
        post_done_noise();
        check($sformatf("vec%0d.done", n),        done,        1'b1);
        check($sformatf("vec%0d.pass", n),        pass,        v.e_pass);
        check($sformatf("vec%0d.fail", n),        fail,        v.e_fail);
        check($sformatf("vec%0d.timeout", n),     timeout,     v.e_to);
        check($sformatf("vec%0d.fail_core", n),   fail_core,   v.e_core);
        check($sformatf("vec%0d.fail_code", n),   fail_code,   v.e_code);
        check($sformatf("vec%0d.cycle_count", n), cycle_count, v.e_cc);
        check($sformatf("vec%0d.core_halted", n), core_halted, v.e_halt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          halt_at [NC];
        logic [31:0] cur     [NC];
        int          r;

        //           mask    cyc  core addr         wdata         c2  wd2    pass  fail  to    core  code           cc      halted
        vecs[0]  = '{4'b1111, -1,  0, TOHOST,       32'h0,        -1, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'd16,  4'b1111};
        vecs[1]  = '{4'b0111, 50,  3, TOHOST,       32'h1,        -1, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'd51,  4'b1111};
        vecs[2]  = '{4'b0000, 30,  1, TOHOST,       32'h7,        -1, 32'h0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h3,         32'd31,  4'b0000};
        vecs[3]  = '{4'b0000, 30,  2, TOHOST,       32'h0,        -1, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,         32'd120, 4'b0000};
        vecs[4]  = '{4'b0111, 40,  3, 32'h0000_1004, 32'h1,       -1, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,         32'd120, 4'b0111};
        vecs[5]  = '{4'b0111, 119, 3, TOHOST,       32'h1,        -1, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'd120, 4'b1111};
        vecs[6]  = '{4'b0000, 0,   0, TOHOST,       32'hFFFF_FFFF, -1, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h7FFF_FFFF, 32'd1,   4'b0000};
        vecs[7]  = '{4'b0001, 20,  0, TOHOST,       32'h3,        -1, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,         32'd120, 4'b0001};
        vecs[8]  = '{4'b1110, 15,  0, TOHOST,       32'h1,        -1, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'd16,  4'b1111};
        vecs[9]  = '{4'b0000, 119, 3, TOHOST,       32'h2,        -1, 32'h0, 1'b0, 1'b1, 1'b0, 3'd3, 32'h1,         32'd120, 4'b0000};
        vecs[10] = '{4'b0000, 10,  1, TOHOST,       32'h5,         2, 32'h9, 1'b0, 1'b1, 1'b0, 3'd1, 32'h2,         32'd11,  4'b0000};
        vecs[11] = '{4'b1100, 25,  1, TOHOST,       32'h7,         0, 32'h1, 1'b0, 1'b1, 1'b0, 3'd1, 32'h3,         32'd26,  4'b1101};

        for (int n = 0; n < 12; n++) run_vec(n, vecs[n]);

        // Core 0 halts on a self-loop, then its PC moves again: the flag stays.
        reset_dut();
        drive_idle(0, 4'b0001);
        cycle();
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            drive_idle(k + 1, (k < 30) ? 4'b0001 : 4'b0000);
            cycle();
            if (k == 40) begin
                check("sticky.core_halted", core_halted, 4'b0001);
                check("sticky.done",        done,        1'b0);
            end
        end
        check("sticky.timeout",     timeout,     1'b1);
        check("sticky.cycle_count", cycle_count, 32'd120);
        check("sticky.end_halted",  core_halted, 4'b0001);

        // Reset in the middle of RUN clears everything without a clock edge.
        reset_dut();
        drive_idle(0, 4'b0011);
        cycle();
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            drive_idle(k + 1, 4'b0011);
            cycle();
        end
        check("midrst.pre_halted", core_halted, 4'b0011);
        check("midrst.pre_cycles", cycle_count, 32'd31);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.core_halted", core_halted, 4'b0000);
        check("midrst.done",        done,        1'b0);
        check("midrst.pass",        pass,        1'b0);
        check("midrst.cycle_count", cycle_count, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle(0, 4'b0000);
        cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_idle(k + 1, 4'b0000);
            cycle();
        end
        check("midrst.restart_cycles", cycle_count, 32'd5);
        check("midrst.restart_halted", core_halted, 4'b0000);

        // Random scenarios against the model.
        for (int s = 0; s < 30; s++) begin
            reset_dut();
            for (int i = 0; i < NC; i++) begin
                halt_at[i] = $urandom_range(0, 140);
                cur[i]     = 32'(i * 4096);
                s_pc[i]    = cur[i];
            end
            apply();
            cycle();
            for (int k = 0; k < 200 && !done; k++) begin
                @(negedge clk);
                for (int i = 0; i < NC; i++) begin
                    if (k < halt_at[i] || $urandom_range(0, 19) == 0) cur[i] = cur[i] + 32'd4;
                    s_pc[i]   = cur[i];
                    s_we[i]   = ($urandom_range(0, 29) == 0);
                    s_addr[i] = ($urandom_range(0, 3) == 0) ? 32'h0000_1004 : TOHOST;
                    r = $urandom_range(0, 3);
                    s_wdata[i] = (r == 0) ? 32'h0 : (r == 3) ? $urandom : 32'h1;
                end
                apply();
                cycle();
            end
            check("rand.done", done, 1'b1);
            post_done_noise();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
